mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Requester indices: bit positions in req/gnt/rd_valid
   localparam int REQ_CORE = 0;
   localparam int REQ_DMA  = 1;

   // Default bus widths
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int CNT_W      = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select. 'last' is the index of the requester
// granted most recently; on a tie the other requester wins.
module rr_arbiter2
   import mem_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // Lone requester always wins; a tie goes to the one not served last
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant[REQ_CORE] = last;
         grant[REQ_DMA]  = ~last;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter for a core and a DMA master.
// One transaction at a time: IDLE (grant) -> ISSUE (drive bus) -> RESP (reads).
// Optional grant counters are built only when ARB_PERF_COUNTERS_EN is defined;
// otherwise gnt_count0/gnt_count1 read as zero.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [1:0]        wr_ena,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic [1:0]        gnt,
   output logic [1:0]        rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_ena,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy,
   output logic [31:0]       gnt_count0,
   output logic [31:0]       gnt_count1
);

   arb_state_t        state_reg;
   logic              last_reg;
   logic              owner_reg;
   logic              wr_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              mem_wr_ena_reg;
   logic [1:0]        rd_valid_reg;

   logic [1:0]        arb_grant;
   logic              win_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              sel_wr;

   rr_arbiter2 u_rr (
      .req   (req),
      .last  (last_reg),
      .grant (arb_grant)
   );

   // Fields of the winning requester, selected from the one-hot grant
   always_comb begin
      win_idx  = arb_grant[REQ_DMA];
      sel_addr = win_idx ? addr1 : addr0;
      sel_data = win_idx ? wr_data1 : wr_data0;
      sel_wr   = win_idx ? wr_ena[REQ_DMA] : wr_ena[REQ_CORE];
   end

   // Grant is combinational in IDLE so the requester's fields are taken the
   // same cycle gnt is seen; it is suppressed while reset is asserted.
   assign gnt         = (!rst && state_reg == IDLE) ? arb_grant : 2'b00;
   assign busy        = (state_reg != IDLE);
   assign mem_addr    = addr_reg;
   assign mem_wr_data = data_reg;
   assign mem_wr_ena  = mem_wr_ena_reg;
   assign rd_valid    = rd_valid_reg;
   assign rd_data     = (state_reg == RESP) ? mem_rd_data : '0;

   // Arbitration FSM with latched request fields and registered strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_reg       <= 1'b1;
         owner_reg      <= 1'b0;
         wr_reg         <= 1'b0;
         addr_reg       <= '0;
         data_reg       <= '0;
         mem_wr_ena_reg <= 1'b0;
         rd_valid_reg   <= 2'b00;
      end else begin
         mem_wr_ena_reg <= 1'b0;
         rd_valid_reg   <= 2'b00;
         case (state_reg)
            IDLE: begin
               if (req != 2'b00) begin
                  state_reg      <= ISSUE;
                  last_reg       <= win_idx;
                  owner_reg      <= win_idx;
                  wr_reg         <= sel_wr;
                  addr_reg       <= sel_addr;
                  data_reg       <= sel_data;
                  mem_wr_ena_reg <= sel_wr;
               end
            end
            ISSUE: begin
               if (wr_reg) begin
                  state_reg <= IDLE;
               end else begin
                  state_reg    <= RESP;
                  rd_valid_reg <= owner_reg ? 2'b10 : 2'b01;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_PERF_COUNTERS_EN
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         // Saturating per-requester grant counter
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (gnt[gi] && cnt_reg != {CNT_W{1'b1}}) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   endgenerate
   assign gnt_count0 = g_cnt[0].cnt_reg;
   assign gnt_count1 = g_cnt[1].cnt_reg;
`else
   assign gnt_count0 = 32'd0;
   assign gnt_count1 = 32'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, reset corner case,
// then randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [31:0] addr0, addr1;
   logic [1:0]  wr_ena;
   logic [31:0] wr_data0, wr_data1;
   logic [1:0]  gnt;
   logic [1:0]  rd_valid;
   logic [31:0] rd_data;
   logic [31:0] mem_addr;
   logic        mem_wr_ena;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;
   logic        busy;
   logic [31:0] gnt_count0, gnt_count1;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .addr0       (addr0),
      .addr1       (addr1),
      .wr_ena      (wr_ena),
      .wr_data0    (wr_data0),
      .wr_data1    (wr_data1),
      .gnt         (gnt),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .mem_addr    (mem_addr),
      .mem_wr_ena  (mem_wr_ena),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data),
      .busy        (busy),
      .gnt_count0  (gnt_count0),
      .gnt_count1  (gnt_count1)
   );

   // Memory: registered read, one cycle latency; init port for preloading
   logic [31:0] mem [256];
   logic        init_en = 1'b0;
   logic [7:0]  init_idx = 8'd0;
   logic [31:0] init_data = 32'd0;
   always @(posedge clk) begin
      if (init_en) mem[init_idx] <= init_data;
      else if (mem_wr_ena) mem[mem_addr[7:0]] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr[7:0]];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   logic [31:0] shadow [256];

   task automatic poke(input logic [7:0] idx, input logic [31:0] data);
      init_en = 1'b1; init_idx = idx; init_data = data; shadow[idx] = data;
      @(posedge clk); #1;
      init_en = 1'b0;
   endtask

   task automatic init_mem();
      for (int i = 0; i < 256; i++) poke(i[7:0], $urandom);
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  wr;
      logic [31:0] a0, a1, d0, d1;
      logic [1:0]  exp_gnt;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl [8];

   // Reference model state for the random phase
   logic        pend   [2];
   logic [31:0] f_addr [2];
   logic [31:0] f_data [2];
   logic        f_wr   [2];
   int          m_last, free_at, iss_cyc, rd_cyc, rd_own, win;
   logic        iss_wr;
   logic [31:0] iss_addr, iss_data, rd_exp, tmp;
   int          m_cnt [2];
   logic [1:0]  exp_gnt, exp_rv;
   logic        busy_exp, is_wr;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF};
      tbl[1] = '{2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 2'b10, 32'h14, 32'h0, 32'hCAFEF00D};
      tbl[2] = '{2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF};
      tbl[3] = '{2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 2'b10, 32'h14, 32'h0, 32'hCAFEF00D};
      tbl[4] = '{2'b10, 2'b10, 32'h44, 32'h20, 32'h0BADBAD0, 32'h12345678, 2'b10, 32'h20, 32'h12345678, 32'h0};
      tbl[5] = '{2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0, 2'b01, 32'h20, 32'h0, 32'h12345678};
      tbl[6] = '{2'b01, 2'b01, 32'h30, 32'h0, 32'hA5A5A5A5, 32'h0, 2'b01, 32'h30, 32'hA5A5A5A5, 32'h0};
      tbl[7] = '{2'b01, 2'b00, 32'h30, 32'h0, 32'h0, 32'h0, 2'b01, 32'h30, 32'h0, 32'hA5A5A5A5};

      rst = 1'b1; req = 2'b00; wr_ena = 2'b00;
      addr0 = '0; addr1 = '0; wr_data0 = '0; wr_data1 = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      poke(8'h10, 32'hDEADBEEF);
      poke(8'h14, 32'hCAFEF00D);
      @(negedge clk);
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_rd_valid", rd_valid, 2'b00);
      chk("reset_mem_wr_ena", mem_wr_ena, 1'b0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wr_data", mem_wr_data, 32'h0);
      chk("reset_cnt0", gnt_count0, 32'h0);
      chk("reset_cnt1", gnt_count1, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed vector table: each entry is one transaction
      for (int i = 0; i < 8; i++) begin
         req = tbl[i].req; wr_ena = tbl[i].wr;
         addr0 = tbl[i].a0; addr1 = tbl[i].a1;
         wr_data0 = tbl[i].d0; wr_data1 = tbl[i].d1;
         is_wr = |(tbl[i].wr & tbl[i].exp_gnt);
         @(negedge clk);
         chk("tbl_gnt", gnt, tbl[i].exp_gnt);
         chk("tbl_idle_busy", busy, 1'b0);
         chk("tbl_idle_wr_ena", mem_wr_ena, 1'b0);
         @(posedge clk); #1;
         // Scramble fields while busy; req stays held and must be ignored
         addr0 = $urandom; addr1 = $urandom;
         wr_data0 = $urandom; wr_data1 = $urandom; wr_ena = 2'($urandom);
         @(negedge clk);
         chk("tbl_issue_gnt", gnt, 2'b00);
         chk("tbl_issue_busy", busy, 1'b1);
         chk("tbl_issue_wr_ena", mem_wr_ena, is_wr);
         chk("tbl_issue_addr", mem_addr, tbl[i].exp_addr);
         chk("tbl_issue_rd_valid", rd_valid, 2'b00);
         if (is_wr) chk("tbl_issue_wdata", mem_wr_data, tbl[i].exp_wdata);
         @(posedge clk); #1;
         if (!is_wr) begin
            @(negedge clk);
            chk("tbl_resp_gnt", gnt, 2'b00);
            chk("tbl_resp_rd_valid", rd_valid, tbl[i].exp_gnt);
            chk("tbl_resp_rd_data", rd_data, tbl[i].exp_rd);
            chk("tbl_resp_wr_ena", mem_wr_ena, 1'b0);
            @(posedge clk); #1;
         end
         $display("tbl %0d: req=%b gnt=%b %s addr=0x%0h", i, tbl[i].req, tbl[i].exp_gnt,
                  is_wr ? "WR" : "RD", tbl[i].exp_addr);
      end
      req = 2'b00;

`ifdef ARB_PERF_COUNTERS_EN
      chk("tbl_cnt0", gnt_count0, 32'd5);
      chk("tbl_cnt1", gnt_count1, 32'd3);
`else
      chk("tbl_cnt0", gnt_count0, 32'd0);
      chk("tbl_cnt1", gnt_count1, 32'd0);
`endif

      // Reset during ISSUE of a read abandons it and restores the tie pointer
      req = 2'b01; wr_ena = 2'b00; addr0 = 32'h14;
      @(negedge clk);
      chk("rst_mid_gnt", gnt, 2'b01);
      @(posedge clk); #1;
      rst = 1'b1; req = 2'b11;
      @(posedge clk); #1;
      rst = 1'b0; addr0 = 32'h10; addr1 = 32'h14;
      @(negedge clk);
      chk("rst_mid_rd_valid", rd_valid, 2'b00);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_tie_gnt", gnt, 2'b01);
      chk("rst_mid_cnt0", gnt_count0, 32'h0);
      chk("rst_mid_cnt1", gnt_count1, 32'h0);
      @(posedge clk); #1;
      req = 2'b00;
      @(negedge clk);
      chk("rst_mid_issue_addr", mem_addr, 32'h10);
      chk("rst_mid_issue_rv", rd_valid, 2'b00);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid_resp_rv", rd_valid, 2'b01);
      chk("rst_mid_resp_data", rd_data, 32'hDEADBEEF);
      @(posedge clk); #1;
      $display("rst_mid: read abandoned, retry tie granted to core");

      // Randomized traffic against the transaction-level model
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      init_mem();
      m_last = 1; free_at = 0; iss_cyc = -1; rd_cyc = -1; rd_own = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      iss_wr = 1'b0; iss_addr = '0; iss_data = '0; rd_exp = '0;
      for (int r = 0; r < 2; r++) begin
         pend[r] = 1'b0; f_addr[r] = '0; f_data[r] = '0; f_wr[r] = 1'b0;
      end
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
               pend[r] = 1'($urandom_range(0, 1));
               tmp = $urandom; tmp[7:0] = 8'($urandom_range(0, 15));
               f_addr[r] = tmp;
               f_data[r] = $urandom;
               f_wr[r] = 1'($urandom_range(0, 1));
            end
         end
         req = {pend[1], pend[0]};
         addr0 = f_addr[0]; addr1 = f_addr[1];
         wr_data0 = f_data[0]; wr_data1 = f_data[1];
         wr_ena = {f_wr[1], f_wr[0]};
         @(negedge clk);
         busy_exp = (cyc < free_at);
         win = -1;
         if (!busy_exp && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) win = (m_last == 1) ? 0 : 1;
            else win = pend[0] ? 0 : 1;
         end
         exp_gnt = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
         chk("rnd_gnt", gnt, exp_gnt);
         chk("rnd_busy", busy, busy_exp);
         chk("rnd_wr_ena", mem_wr_ena, (cyc == iss_cyc) && iss_wr);
         if (cyc == iss_cyc) begin
            chk("rnd_addr", mem_addr, iss_addr);
            if (iss_wr) chk("rnd_wdata", mem_wr_data, iss_data);
         end
         exp_rv = (cyc != rd_cyc) ? 2'b00 : (rd_own == 1) ? 2'b10 : 2'b01;
         chk("rnd_rd_valid", rd_valid, exp_rv);
         if (cyc == rd_cyc) chk("rnd_rd_data", rd_data, rd_exp);
         if (win >= 0) begin
            iss_cyc = cyc + 1; iss_wr = f_wr[win];
            iss_addr = f_addr[win]; iss_data = f_data[win];
            if (iss_wr) begin
               shadow[iss_addr[7:0]] = iss_data;
               rd_cyc = -1; free_at = cyc + 2;
            end else begin
               rd_cyc = cyc + 2; rd_own = win;
               rd_exp = shadow[iss_addr[7:0]]; free_at = cyc + 3;
            end
            m_last = win; m_cnt[win]++; pend[win] = 1'b0;
            $display("rnd cyc %0d: gnt requester %0d %s addr=0x%0h", cyc, win,
                     iss_wr ? "WR" : "RD", iss_addr);
         end
         @(posedge clk); #1;
      end
      req = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
`ifdef ARB_PERF_COUNTERS_EN
      chk("rnd_cnt0", gnt_count0, 32'(m_cnt[0]));
      chk("rnd_cnt1", gnt_count1, 32'(m_cnt[1]));
`else
      chk("rnd_cnt0", gnt_count0, 32'd0);
      chk("rnd_cnt1", gnt_count1, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
